// File: rtl/search_sequencer.sv
// search_sequencer
//   Drives the brute-force MD5 search across LANES parallel hash pipelines.
//   One base count is issued per cycle; every lane appends its own index as
//   the low candidate bits. A delay line matched to PIPE_LATENCY follows each
//   issued base so that a lane's found pulse maps back to its exact candidate.
//   Owns the run/step/stop/done control and latches the winning candidate.
//
//   Optional feature macro: FOUND_RESUME_EN (adds the 'resume' input, which
//   restarts the search just past the latched match).
//
// Ports:
//   CLK          system clock
//   reset        synchronous, active-high; clears all control state
//   enable       level; run continuously while high
//   step         one-cycle pulse; issue a single base while idle
//   resume       (FOUND_RESUME_EN only) pulse; continue after a match
//   found_in     per-lane match bits, aligned with the delay-line tap
//   base_count   base presented to the pipelines this cycle
//   issue_valid  base_count is a live candidate this cycle
//   running      high while searching or draining
//   done         whole space searched without a match
//   found        a match is latched
//   found_lane   lane of the latched match
//   found_value  latched candidate {base, lane}
//
// PIPE_LATENCY must be at least 2.

module search_sequencer #(
    parameter int LANES        = 8,
    parameter int LANE_BITS    = 3,
    parameter int COUNT_BITS   = 29,
    parameter int PIPE_LATENCY = 65
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            step,
`ifdef FOUND_RESUME_EN
    input  logic                            resume,
`endif
    input  logic [LANES-1:0]                found_in,
    output logic [COUNT_BITS-1:0]           base_count,
    output logic                            issue_valid,
    output logic                            running,
    output logic                            done,
    output logic                            found,
    output logic [LANE_BITS-1:0]            found_lane,
    output logic [COUNT_BITS+LANE_BITS-1:0] found_value
);

    localparam int CW = COUNT_BITS + LANE_BITS;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_HIT, S_DONE} state_t;

    state_t                  r_state;
    logic [COUNT_BITS-1:0]   r_base;
    logic                    r_issue_valid;
    logic                    r_running;
    logic                    r_done;
    logic                    r_found;
    logic [LANE_BITS-1:0]    r_found_lane;
    logic [CW-1:0]           r_found_value;

    // Delay line: valid bits are control (reset), base values are data.
    logic [PIPE_LATENCY-1:0] r_dl_vld;
    logic [COUNT_BITS-1:0]   r_dl_base [PIPE_LATENCY];

    logic                    w_tap_vld;
    logic [COUNT_BITS-1:0]   w_tap_base;
    logic [LANES-1:0]        w_hits;
    logic                    w_match;
    logic [LANE_BITS-1:0]    w_hit_lane;
    logic                    w_inflight;
    logic                    w_last_base;
    logic [COUNT_BITS-1:0]   w_next_base;

    // Lowest set lane wins when several lanes of one base match together.
    function automatic logic [LANE_BITS-1:0] lowest_lane(input logic [LANES-1:0] v);
        lowest_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) lowest_lane = LANE_BITS'(i);
        end
    endfunction

    assign w_tap_vld   = r_dl_vld[PIPE_LATENCY-1];
    assign w_tap_base  = r_dl_base[PIPE_LATENCY-1];
    assign w_hits      = w_tap_vld ? found_in : '0;
    assign w_match     = |w_hits;
    assign w_hit_lane  = lowest_lane(w_hits);
    // The tap entry leaves the line at this edge, so only the stages ahead
    // of it decide whether anything is still in flight next cycle. This lets
    // done rise one cycle after the last tap instead of two.
    assign w_inflight  = |r_dl_vld[PIPE_LATENCY-2:0];
    assign w_last_base = &r_base;
    // The all-ones base is the final candidate; the counter never wraps.
    assign w_next_base = (r_issue_valid && !w_last_base) ? r_base + COUNT_BITS'(1) : r_base;

    always_ff @(posedge CLK) begin
        r_dl_base[0] <= r_base;
        for (int i = 1; i < PIPE_LATENCY; i++) begin
            r_dl_base[i] <= r_dl_base[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_issue_valid <= 1'b0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_found_lane  <= '0;
            r_found_value <= '0;
            r_dl_vld      <= '0;
        end else begin
            r_dl_vld <= {r_dl_vld[PIPE_LATENCY-2:0], r_issue_valid};
            r_base   <= w_next_base;
            case (r_state)
                S_IDLE, S_RUN, S_DRAIN: begin
                    if (w_match) begin
                        r_state       <= S_HIT;
                        r_found       <= 1'b1;
                        r_found_lane  <= w_hit_lane;
                        r_found_value <= {w_tap_base, w_hit_lane};
                        r_issue_valid <= 1'b0;
                        r_running     <= 1'b0;
                    end else if (r_issue_valid && w_last_base) begin
                        r_state       <= S_DRAIN;
                        r_issue_valid <= 1'b0;
                        r_running     <= 1'b1;
                    end else if (r_state == S_IDLE) begin
                        if (enable) begin
                            r_state       <= S_RUN;
                            r_issue_valid <= 1'b1;
                            r_running     <= 1'b1;
                        end else begin
                            r_issue_valid <= step;
                        end
                    end else if (r_state == S_RUN) begin
                        if (!enable) begin
                            r_state       <= S_IDLE;
                            r_issue_valid <= 1'b0;
                            r_running     <= 1'b0;
                        end
                    end else if (!w_inflight) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_running <= 1'b0;
                    end
                end
                S_HIT: begin
`ifdef FOUND_RESUME_EN
                    if (resume) begin
                        r_found  <= 1'b0;
                        r_dl_vld <= '0;
                        if (&r_found_value[CW-1:LANE_BITS]) begin
                            // Match was on the last base: nothing left to search.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_base        <= r_found_value[CW-1:LANE_BITS] + COUNT_BITS'(1);
                            r_state       <= enable ? S_RUN : S_IDLE;
                            r_issue_valid <= enable;
                            r_running     <= enable;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign base_count  = r_base;
    assign issue_valid = r_issue_valid;
    assign running     = r_running;
    assign done        = r_done;
    assign found       = r_found;
    assign found_lane  = r_found_lane;
    assign found_value = r_found_value;

endmodule

// File: tb/tb_search_sequencer.sv
// Testbench for search_sequencer (COUNT_BITS=6, LANE_BITS=3, PIPE_LATENCY=4).
// A stub pipeline answers each issued base PIPE_LATENCY cycles later from a
// per-base hit-mask table. A behavioural model tracks issues by absolute cycle
// number and predicts every output each cycle.

module tb_search_sequencer;

    localparam int LANES = 8;
    localparam int LB    = 3;
    localparam int CB    = 6;
    localparam int L     = 4;
    localparam int MAXB  = 63;
    localparam int HSZ   = 16384;

    localparam int MI = 0, MR = 1, MD = 2, MH = 3, MX = 4;

    logic          CLK = 1'b0;
    logic          reset;
    logic          enable;
    logic          step;
`ifdef FOUND_RESUME_EN
    logic          resume;
`endif
    logic [7:0]    found_in;
    logic [CB-1:0] base_count;
    logic          issue_valid;
    logic          running;
    logic          done;
    logic          found;
    logic [LB-1:0] found_lane;
    logic [CB+LB-1:0] found_value;

    search_sequencer #(
        .LANES(LANES), .LANE_BITS(LB), .COUNT_BITS(CB), .PIPE_LATENCY(L)
    ) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .step(step),
`ifdef FOUND_RESUME_EN
        .resume(resume),
`endif
        .found_in(found_in), .base_count(base_count), .issue_valid(issue_valid),
        .running(running), .done(done), .found(found),
        .found_lane(found_lane), .found_value(found_value)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   cyc = 0;
    bit   m_ready = 0;
    int   m_mode;
    logic m_iv, m_run, m_done, m_found;
    int   m_base, m_lane, m_value;
    bit   hist_v [HSZ];
    int   hist_b [HSZ];
    int   flush_cyc = -1000;
    int   last_issue = -1000;

    initial forever begin
        int k, tk, nb, lane;
        bit tv;
        logic [7:0] q;
        @(posedge CLK);
        k = cyc;
        if (m_ready) begin
            hist_v[k] = m_iv;
            hist_b[k] = m_base;
            if (m_iv) last_issue = k;
        end
        if (reset) begin
            m_ready = 1; m_mode = MI; m_iv = 0; m_run = 0; m_done = 0; m_found = 0;
            m_base = 0; m_lane = 0; m_value = 0; flush_cyc = k; last_issue = -1000;
        end else if (m_ready) begin
            tk = k - L;
            tv = (tk >= 0) && (tk > flush_cyc) && hist_v[tk];
            q  = tv ? found_in : 8'h00;
            nb = (m_iv && m_base != MAXB) ? m_base + 1 : m_base;
            if ((m_mode == MI || m_mode == MR || m_mode == MD) && q != 0) begin
                lane = 0;
                for (int i = 0; i < LANES; i++) if (q[i]) begin lane = i; break; end
                m_found = 1; m_lane = lane; m_value = hist_b[tk] * 8 + lane;
                m_mode = MH; m_iv = 0; m_run = 0; m_base = nb;
            end else if ((m_mode == MI || m_mode == MR) && m_iv && m_base == MAXB) begin
                m_mode = MD; m_iv = 0; m_run = 1;
            end else begin
                case (m_mode)
                    MI: begin
                        m_base = nb;
                        if (enable) begin m_mode = MR; m_iv = 1; m_run = 1; end
                        else m_iv = step;
                    end
                    MR: begin
                        m_base = nb;
                        if (!enable) begin m_mode = MI; m_iv = 0; m_run = 0; end
                    end
                    MD: if (k - last_issue >= L) begin m_mode = MX; m_done = 1; m_run = 0; end
                    MH: begin
`ifdef FOUND_RESUME_EN
                        if (resume) begin
                            m_found = 0; flush_cyc = k;
                            if (m_value / 8 == MAXB) begin m_mode = MX; m_done = 1; end
                            else begin
                                m_base = m_value / 8 + 1;
                                m_mode = enable ? MR : MI; m_iv = enable; m_run = enable;
                            end
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- compare + observation ----------------
    bit obs_v [HSZ];
    int obs_b [HSZ];

    initial forever begin
        @(negedge CLK);
        obs_v[cyc] = (issue_valid === 1'b1);
        obs_b[cyc] = int'(base_count);
        if (m_ready) begin
            chk("issue_valid", issue_valid, m_iv);
            chk("base_count",  base_count,  m_base);
            chk("running",     running,     m_run);
            chk("done",        done,        m_done);
            chk("found",       found,       m_found);
            chk("found_lane",  found_lane,  m_lane);
            chk("found_value", found_value, m_value);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] hit_mask [64];
    bit         stub_en;
    bit         noise_en;
    logic [7:0] manual_fi;

    task automatic tick();
        int k;
        @(posedge CLK);
        #1;
        k = cyc;
        if (stub_en) begin
            if (k >= L && obs_v[k-L]) found_in = hit_mask[obs_b[k-L]];
            else found_in = noise_en ? 8'($urandom) : 8'h00;
        end else begin
            found_in = manual_fi;
        end
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; step = 0;
`ifdef FOUND_RESUME_EN
        resume = 0;
`endif
        stub_en = 1; noise_en = 0; manual_fi = 0;
        for (int b = 0; b < 64; b++) hit_mask[b] = 8'h00;
        tick(); tick();
        reset = 0;
    endtask

    task automatic run_until_found(input string name);
        int n;
        n = 0;
        while (found !== 1'b1 && n < 150) begin tick(); n++; end
        if (found !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n_issue, t63, t_done, n;
        bit seq_ok;
        reset = 1; enable = 0; step = 0; found_in = 0;
`ifdef FOUND_RESUME_EN
        resume = 0;
`endif
        stub_en = 0; noise_en = 0; manual_fi = 0;
        do_reset();

        // 1. exhaustive run, no match
        enable = 1;
        n_issue = 0; t63 = -1; t_done = -1; seq_ok = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (issue_valid === 1'b1) begin
                if (int'(base_count) != n_issue) seq_ok = 0;
                n_issue++;
                if (base_count == 6'd63) t63 = cyc;
            end
            if (done === 1'b1) begin t_done = cyc; break; end
        end
        if (t_done < 0) chk("t1_done_timeout", 0, 1);
        chk("t1_issues", n_issue, 64);
        chk("t1_sequence", seq_ok, 1);
        chk("t1_done_delay", t_done - t63, 5);
        chk("t1_running", running, 0);
        chk("t1_found", found, 0);

        // 2. single match on base 5, lane 5
        do_reset();
        hit_mask[5] = 8'h20;
        enable = 1;
        run_until_found("t2");
        chk("t2_lane", found_lane, 5);
        chk("t2_value", found_value, 45);
        chk("t2_issue_valid", issue_valid, 0);
        chk("t2_running", running, 0);
        repeat (5) tick();
        chk("t2_hold_value", found_value, 45);

        // 3. simultaneous lanes on base 9
        do_reset();
        hit_mask[9] = 8'h84;
        enable = 1;
        run_until_found("t3");
        chk("t3_lane", found_lane, 2);
        chk("t3_value", found_value, 74);

        // 4. unqualified found_in
        do_reset();
        stub_en = 0; manual_fi = 8'hFF;
        repeat (10) tick();
        chk("t4_found", found, 0);
        chk("t4_issue_valid", issue_valid, 0);
        manual_fi = 0; stub_en = 1;

        // 5. step mode
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step = 1;
            tick();
            chk("t5_step_issue", issue_valid, 1);
            chk("t5_step_base", base_count, i);
            step = 0;
            repeat (9) tick();
        end
        chk("t5_base_after", base_count, 3);
        chk("t5_idle_running", running, 0);
        enable = 1; step = 1;
        tick();
        step = 0;
        chk("t5_run_running", running, 1);
        chk("t5_run_base", base_count, 3);
        tick();
        chk("t5_run_next", base_count, 4);

        // 6. reset mid-run, stale found_in ignored
        do_reset();
        enable = 1;
        n = 0;
        while (!(issue_valid === 1'b1 && base_count == 6'd20) && n < 100) begin tick(); n++; end
        if (n >= 100) chk("t6_base20_timeout", 0, 1);
        reset = 1; enable = 0;
        tick();
        reset = 0; stub_en = 0; manual_fi = 8'h01;
        repeat (6) tick();
        chk("t6_found", found, 0);
        chk("t6_base", base_count, 0);
        chk("t6_issue_valid", issue_valid, 0);
        chk("t6_running", running, 0);
        manual_fi = 0; stub_en = 1;

`ifdef FOUND_RESUME_EN
        do_reset();
        hit_mask[5] = 8'h01;
        enable = 1;
        run_until_found("t7");
        chk("t7_value", found_value, 40);
        resume = 1;
        tick();
        resume = 0;
        chk("t7_found_cleared", found, 0);
        chk("t7_issue_valid", issue_valid, 1);
        chk("t7_first_base", base_count, 6);
`endif

        // randomized rounds against the model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            if (r % 2 == 0)
                for (int b = 0; b < 64; b++)
                    hit_mask[b] = ($urandom % 16 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            noise_en = 1;
            enable = (r % 3 != 0);
            for (int c = 0; c < 220; c++) begin
                if ($urandom % 15 == 0) enable = ~enable;
                step  = ($urandom % 6 == 0);
                reset = ($urandom % 250 == 0);
`ifdef FOUND_RESUME_EN
                resume = ($urandom % 8 == 0);
`endif
                tick();
            end
            reset = 0; step = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
